// File: rtl/inst_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into 32-bit words and
// writes them from address 0 up to and including the halt sentinel.
module inst_loader #(
    parameter int          ADDR_W    = 8,
    parameter int          MAX_WORDS = 1 << ADDR_W,
    parameter logic [31:0] SENTINEL  = 32'hffffffff
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count
);

    // Byte handshake: a byte transfers on a rising edge where rx_valid and
    // rx_ready are both high; rx_ready is high only in RECV and never depends
    // on rx_valid, so the sender may hold a byte for any number of cycles.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_WORDS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        byte_cnt;
    logic [31:0]       shreg;
    logic [ADDR_W:0]   count;
    logic              accept;
    logic              is_sentinel;
    logic              at_last;

    assign accept      = rx_valid && rx_ready;
    assign is_sentinel = (shreg == SENTINEL);
    assign at_last     = (addr == LAST_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_next = S_RECV;
            end
            S_RECV: begin
                if (accept && (byte_cnt == 2'd3)) state_next = S_WRITE;
            end
            S_WRITE: begin
                // A sentinel in the last slot is a clean finish, not an overflow.
                if (is_sentinel)  state_next = S_DONE;
                else if (at_last) state_next = S_ERR;
                else              state_next = S_RECV;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        rx_ready = 1'b0;
        wr_en    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        overflow = 1'b0;
        case (state)
            S_RECV: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
            S_WRITE: begin
                wr_en = 1'b1;
                busy  = 1'b1;
            end
            S_DONE:  done     = 1'b1;
            S_ERR:   overflow = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr     <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            count    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        addr     <= '0;
                        byte_cnt <= '0;
                        shreg    <= '0;
                        count    <= '0;
                    end
                end
                S_RECV: begin
                    if (accept) begin
                        shreg    <= {shreg[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                S_WRITE: begin
                    count <= count + COUNT_ONE;
                    if (!is_sentinel && !at_last) addr <= addr + ADDR_ONE;
                end
                default: ;
            endcase
        end
    end

    assign wr_addr    = addr;
    assign wr_data    = shreg;
    assign word_count = count;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: an 8-bit-address instance for the main loads and
// a 2-bit-address instance for capacity limits, selected onto one set of probes.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        sel;

    logic        rdy1, wen1, busy1, done1, ovf1;
    logic [7:0]  wa1;
    logic [31:0] wd1;
    logic [8:0]  wc1;
    logic        rdy2, wen2, busy2, done2, ovf2;
    logic [1:0]  wa2;
    logic [31:0] wd2;
    logic [2:0]  wc2;

    logic        rdy_m, wen_m, busy_m, done_m, ovf_m;
    logic [7:0]  wa_m;
    logic [31:0] wd_m;
    logic [8:0]  wc_m;

    logic [39:0] exp_q[$];
    logic [39:0] got_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    inst_loader #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rdy1), .wr_en(wen1), .wr_addr(wa1), .wr_data(wd1), .busy(busy1),
        .done(done1), .overflow(ovf1), .word_count(wc1)
    );

    inst_loader #(.ADDR_W(2)) dut_small (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rdy2), .wr_en(wen2), .wr_addr(wa2), .wr_data(wd2), .busy(busy2),
        .done(done2), .overflow(ovf2), .word_count(wc2)
    );

    assign rdy_m  = sel ? rdy2  : rdy1;
    assign wen_m  = sel ? wen2  : wen1;
    assign busy_m = sel ? busy2 : busy1;
    assign done_m = sel ? done2 : done1;
    assign ovf_m  = sel ? ovf2  : ovf1;
    assign wa_m   = sel ? {6'd0, wa2} : wa1;
    assign wd_m   = sel ? wd2 : wd1;
    assign wc_m   = sel ? {6'd0, wc2} : wc1;

    // clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wen_m) got_q.push_back({wa_m, wd_m});
    end

    // driver tasks (called at a falling edge, return at a falling edge)
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (rdy_m !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n >= 20) begin
            n_err++;
            $display("FAIL handshake_timeout byte=%h waited=%0d cycles, required ready within 20", b, n);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], gap);
        n_cmp++;
        if (wen_m !== 1'b1 || rdy_m !== 1'b0) begin
            n_err++;
            $display("FAIL write_cycle word=%h wr_en=%b rx_ready=%b, required wr_en=1 rx_ready=0",
                     w, wen_m, rdy_m);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; sel = 1'b0;
        #2;
        n_cmp++;
        if ({rdy_m, wen_m, busy_m, done_m, ovf_m} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags got=%b required=00000", {rdy_m, wen_m, busy_m, done_m, ovf_m});
        end
        n_cmp++;
        if (wa_m !== 8'd0 || wd_m !== 32'd0 || wc_m !== 9'd0) begin
            n_err++;
            $display("FAIL reset_regs addr=%h data=%h count=%0d required 0/0/0", wa_m, wd_m, wc_m);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rdy_m !== 1'b0 || busy_m !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ready rx_ready=%b busy=%b required 0/0", rdy_m, busy_m);
        end
    endtask

    task automatic test_basic_load(input int gap, input string tag);
        got_q.delete();
        exp_q = '{{8'd0, 32'h20010014}, {8'd1, 32'h0c00000d}, {8'd2, 32'hffffffff}};
        pulse_start();
        n_cmp++;
        if (busy_m !== 1'b1 || rdy_m !== 1'b1 || done_m !== 1'b0 || wc_m !== 9'd0) begin
            n_err++;
            $display("FAIL %s_start busy=%b ready=%b done=%b count=%0d required 1/1/0/0",
                     tag, busy_m, rdy_m, done_m, wc_m);
        end
        send_word(32'h20010014, gap);
        send_word(32'h0c00000d, gap);
        send_word(32'hffffffff, gap);
        @(negedge clk);
        n_cmp++;
        if (done_m !== 1'b1 || busy_m !== 1'b0 || rdy_m !== 1'b0 || ovf_m !== 1'b0 || wc_m !== 9'd3) begin
            n_err++;
            $display("FAIL %s_end done=%b busy=%b ready=%b ovf=%b count=%0d required 1/0/0/0/3",
                     tag, done_m, busy_m, rdy_m, ovf_m, wc_m);
        end
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL %s_write_count got=%0d required=%0d", tag, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL %s_write%0d got=%h required=%h", tag, i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_small_overflow();
        sel = 1'b1;
        got_q.delete();
        exp_q = '{{8'd0, 32'h1}, {8'd1, 32'h2}, {8'd2, 32'h3}, {8'd3, 32'h4}};
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        for (int i = 1; i <= 4; i++) send_word(32'(i), 0);
        @(negedge clk);
        n_cmp++;
        if (ovf_m !== 1'b1 || done_m !== 1'b0 || busy_m !== 1'b0 || wc_m !== 9'd4) begin
            n_err++;
            $display("FAIL ovf_flags ovf=%b done=%b busy=%b count=%0d required 1/0/0/4",
                     ovf_m, done_m, busy_m, wc_m);
        end
        rx_data  = 8'haa;
        rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rdy_m !== 1'b0) begin
                n_err++;
                $display("FAIL ovf_ready cycle=%0d ready=%b required 0", i, rdy_m);
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL ovf_write_count got=%0d required=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL ovf_write%0d got=%h required=%h", i, got_q[i], exp_q[i]);
            end
        end
        // restart from ERR, sentinel lands exactly in the last slot
        got_q.delete();
        exp_q = '{{8'd0, 32'h5}, {8'd1, 32'h6}, {8'd2, 32'h7}, {8'd3, 32'hffffffff}};
        pulse_start();
        n_cmp++;
        if (ovf_m !== 1'b0 || busy_m !== 1'b1 || wc_m !== 9'd0) begin
            n_err++;
            $display("FAIL ovf_restart ovf=%b busy=%b count=%0d required 0/1/0", ovf_m, busy_m, wc_m);
        end
        send_word(32'h5, 0);
        send_word(32'h6, 0);
        send_word(32'h7, 0);
        send_word(32'hffffffff, 0);
        @(negedge clk);
        n_cmp++;
        if (done_m !== 1'b1 || ovf_m !== 1'b0 || wc_m !== 9'd4) begin
            n_err++;
            $display("FAIL last_slot_sentinel done=%b ovf=%b count=%0d required 1/0/4", done_m, ovf_m, wc_m);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL last_slot_write%0d got=%h required=%h", i,
                         (i < got_q.size()) ? got_q[i] : 40'hx, exp_q[i]);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_word();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        exp_q = '{{8'd0, 32'h03e00008}, {8'd1, 32'hffffffff}};
        pulse_start();
        send_byte(8'h20, 0);
        send_byte(8'h01, 0);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({rdy_m, wen_m, busy_m, done_m, ovf_m} !== 5'b0 || wd_m !== 32'd0 || wa_m !== 8'd0 || wc_m !== 9'd0) begin
            n_err++;
            $display("FAIL mid_reset flags=%b data=%h addr=%h count=%0d required all 0",
                     {rdy_m, wen_m, busy_m, done_m, ovf_m}, wd_m, wa_m, wc_m);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_start();
        send_word(32'h03e00008, 1);
        send_word(32'hffffffff, 0);
        @(negedge clk);
        n_cmp++;
        if (done_m !== 1'b1 || wc_m !== 9'd2) begin
            n_err++;
            $display("FAIL mid_reset_end done=%b count=%0d required 1/2", done_m, wc_m);
        end
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL mid_reset_write_count got=%0d required=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL mid_reset_write%0d got=%h required=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        got_q.delete();
        exp_q = '{{8'd0, 32'h00000011}, {8'd1, 32'h00000022}, {8'd2, 32'hffffffff}};
        pulse_start();
        send_word(32'h00000011, 0);
        send_word(32'h00000022, 0);
        send_byte(8'hff, 0);
        send_byte(8'hff, 0);
        pulse_start();
        send_byte(8'hff, 0);
        send_byte(8'hff, 0);
        @(negedge clk);
        n_cmp++;
        if (done_m !== 1'b1 || wc_m !== 9'd3) begin
            n_err++;
            $display("FAIL busy_start_end done=%b count=%0d required 1/3", done_m, wc_m);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL busy_start_write%0d got=%h required=%h", i,
                         (i < got_q.size()) ? got_q[i] : 40'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_sentinel_first();
        got_q.delete();
        exp_q = '{{8'd0, 32'hffffffff}};
        pulse_start();
        n_cmp++;
        if (done_m !== 1'b0 || wc_m !== 9'd0) begin
            n_err++;
            $display("FAIL reload_clear done=%b count=%0d required 0/0", done_m, wc_m);
        end
        send_word(32'hffffffff, 0);
        @(negedge clk);
        n_cmp++;
        if (done_m !== 1'b1 || wc_m !== 9'd1 || busy_m !== 1'b0) begin
            n_err++;
            $display("FAIL sentinel_first done=%b count=%0d busy=%b required 1/1/0", done_m, wc_m, busy_m);
        end
        n_cmp++;
        if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin
            n_err++;
            $display("FAIL sentinel_first_write n=%0d got=%h required=%h", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 40'hx, exp_q[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load(0, "plain");
        test_basic_load(3, "gapped");
        test_start_while_busy();
        test_sentinel_first();
        test_reset_mid_word();
        test_small_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule
